// File: rtl/instruction_sequencer.sv
// Program-memory instruction sequencer: loads a program, then issues each word to the CPU
// for ISSUE_INTERVAL cycles, folding cpu_output into a rotating XOR signature.
module instruction_sequencer #(
   parameter int                     INSTR_WIDTH    = 16,
   parameter int                     DEPTH          = 1024,
   parameter int                     ISSUE_INTERVAL = 2,
   parameter logic [INSTR_WIDTH-1:0] HALT_WORD      = 16'hFFFF,
   parameter logic [INSTR_WIDTH-1:0] NOP_WORD       = 16'h9000,
   parameter int                     BUS_WIDTH      = 7,
   localparam int                    ADDR_W         = $clog2(DEPTH)
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   load_enable,
   input  logic [ADDR_W-1:0]      load_address,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   loop_mode,
   input  logic [BUS_WIDTH:0]     cpu_output,
   output logic [INSTR_WIDTH-1:0] current_instruction,
   output logic                   instruction_valid,
   output logic [15:0]            instruction_count,
   output logic [15:0]            signature,
   output logic                   busy,
   output logic                   done
);

   localparam int                CNT_W     = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ISSUE_INTERVAL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   state_t                 state, state_nx;
   logic [ADDR_W-1:0]      pc, pc_nx, pc_inc;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic [INSTR_WIDTH-1:0] instr_nx;
   logic                   valid_nx;
   logic [15:0]            count_nx, sig_nx, cpu_ext;

   assign cpu_ext = 16'($signed(cpu_output));
   assign pc_inc  = pc + ADDR_W'(1);
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   // Writes are blocked only while running, so a load in the start cycle lands before the first fetch.
   always_ff @(posedge clock_in) begin
      if (load_enable && state != RUN)
         mem[load_address] <= load_data;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state               <= IDLE;
         pc                  <= '0;
         cnt                 <= '0;
         current_instruction <= NOP_WORD;
         instruction_valid   <= 1'b0;
         instruction_count   <= 16'd0;
         signature           <= 16'd0;
      end else begin
         state               <= state_nx;
         pc                  <= pc_nx;
         cnt                 <= cnt_nx;
         current_instruction <= instr_nx;
         instruction_valid   <= valid_nx;
         instruction_count   <= count_nx;
         signature           <= sig_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      cnt_nx   = cnt;
      instr_nx = current_instruction;
      valid_nx = instruction_valid;
      count_nx = instruction_count;
      sig_nx   = signature;
      case (state)
         IDLE, DONE: begin
            instr_nx = NOP_WORD;
            valid_nx = 1'b0;
            if (start) begin
               state_nx = RUN;
               pc_nx    = '0;
               cnt_nx   = '0;
               count_nx = 16'd0;
               sig_nx   = 16'd0;
            end
         end
         RUN: begin
            if (pause) begin
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
            end else if (!instruction_valid) begin
               // First fetch, or reissue after a pause with a fresh interval.
               if (mem[pc] == HALT_WORD) begin
                  if (loop_mode && pc != '0)
                     pc_nx = '0;
                  else
                     state_nx = DONE;
               end else begin
                  instr_nx = mem[pc];
                  valid_nx = 1'b1;
                  cnt_nx   = '0;
               end
            end else if (cnt != CNT_LAST) begin
               cnt_nx = cnt + CNT_W'(1);
            end else begin
               cnt_nx   = '0;
               sig_nx   = {signature[14:0], signature[15]} ^ cpu_ext;
               count_nx = (instruction_count == 16'hFFFF) ? instruction_count
                                                          : instruction_count + 16'd1;
               // Look ahead one word so consecutive issues have no gap; mem[0] was already
               // issued this run, so looping can load it directly.
               if (pc == ADDR_LAST || mem[pc_inc] == HALT_WORD) begin
                  if (loop_mode) begin
                     pc_nx    = '0;
                     instr_nx = mem[0];
                  end else begin
                     if (pc != ADDR_LAST)
                        pc_nx = pc_inc;
                     state_nx = DONE;
                     instr_nx = NOP_WORD;
                     valid_nx = 1'b0;
                  end
               end else begin
                  pc_nx    = pc_inc;
                  instr_nx = mem[pc_inc];
               end
            end
         end
         default: begin
            state_nx = IDLE;
            instr_nx = NOP_WORD;
            valid_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: cycle-by-cycle output vectors per scenario.
module tb_instruction_sequencer;

   localparam int DEPTH = 16;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        load_enable = 1'b0;
   logic [3:0]  load_address = '0;
   logic [15:0] load_data = '0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        loop_mode = 1'b0;
   logic [7:0]  cpu_output = '0;
   logic [15:0] current_instruction;
   logic        instruction_valid;
   logic [15:0] instruction_count;
   logic [15:0] signature;
   logic        busy;
   logic        done;

   int compared = 0;
   int mismatched = 0;

   logic [50:0] obs;
   assign obs = {current_instruction, instruction_valid, busy, done, instruction_count, signature};

   always #5 clock_in = ~clock_in;

   instruction_sequencer #(.DEPTH(DEPTH)) dut (
      .clock_in(clock_in), .reset_in(reset_in), .load_enable(load_enable),
      .load_address(load_address), .load_data(load_data), .start(start),
      .pause(pause), .loop_mode(loop_mode), .cpu_output(cpu_output),
      .current_instruction(current_instruction), .instruction_valid(instruction_valid),
      .instruction_count(instruction_count), .signature(signature),
      .busy(busy), .done(done)
   );

   function automatic logic [50:0] ex(input logic [15:0] i, input logic v, input logic b,
                                      input logic d, input logic [15:0] c, input logic [15:0] s);
      return {i, v, b, d, c, s};
   endfunction

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      load_enable = 1'b1; load_address = a; load_data = d;
      step();
      load_enable = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_in = 1'b1;
      step(); step();
      reset_in = 1'b0;
      compared++;
      if (obs !== ex(16'h9000, 0, 0, 0, 16'h0, 16'h0)) begin
         $display("FAIL reset: got %h want %h", obs, ex(16'h9000, 0, 0, 0, 16'h0, 16'h0));
         mismatched++;
      end
   endtask

   task automatic test_basic();
      logic [50:0] e [7];
      e = '{ex(16'h9000, 0, 1, 0, 16'd0, 16'h0000), ex(16'h1111, 1, 1, 0, 16'd0, 16'h0000),
            ex(16'h1111, 1, 1, 0, 16'd0, 16'h0000), ex(16'h2222, 1, 1, 0, 16'd1, 16'hFFFF),
            ex(16'h2222, 1, 1, 0, 16'd1, 16'hFFFF), ex(16'h9000, 0, 0, 1, 16'd2, 16'h0000),
            ex(16'h9000, 0, 0, 1, 16'd2, 16'h0000)};
      load(4'd0, 16'h1111); load(4'd1, 16'h2222); load(4'd2, 16'hFFFF);
      cpu_output = 8'hFF;
      do_start();
      for (int c = 0; c < 7; c++) begin
         compared++;
         if (obs !== e[c]) begin
            $display("FAIL basic cyc%0d: got %h want %h", c, obs, e[c]);
            mismatched++;
         end
         step();
      end
   endtask

   task automatic test_pause();
      logic [50:0] e [11];
      e = '{ex(16'h9000, 0, 1, 0, 16'd0, 16'h0000), ex(16'h1111, 1, 1, 0, 16'd0, 16'h0000),
            ex(16'h1111, 1, 1, 0, 16'd0, 16'h0000), ex(16'h2222, 1, 1, 0, 16'd1, 16'hFFFF),
            ex(16'h9000, 0, 1, 0, 16'd1, 16'hFFFF), ex(16'h9000, 0, 1, 0, 16'd1, 16'hFFFF),
            ex(16'h9000, 0, 1, 0, 16'd1, 16'hFFFF), ex(16'h2222, 1, 1, 0, 16'd1, 16'hFFFF),
            ex(16'h2222, 1, 1, 0, 16'd1, 16'hFFFF), ex(16'h9000, 0, 0, 1, 16'd2, 16'h0000),
            ex(16'h9000, 0, 0, 1, 16'd2, 16'h0000)};
      cpu_output = 8'hFF;
      do_start();
      for (int c = 0; c < 11; c++) begin
         compared++;
         if (obs !== e[c]) begin
            $display("FAIL pause cyc%0d: got %h want %h", c, obs, e[c]);
            mismatched++;
         end
         if (c == 3) pause = 1'b1;
         if (c == 6) pause = 1'b0;
         step();
      end
   endtask

   // Also checks that start and load_enable are ignored mid-run.
   task automatic test_loop();
      logic [50:0] want;
      int k;
      load(4'd0, 16'hAAAA); load(4'd1, 16'hBBBB); load(4'd2, 16'hFFFF);
      cpu_output = 8'h01;
      loop_mode = 1'b1;
      do_start();
      for (int c = 0; c < 15; c++) begin
         k = (c - 1) / 2;
         if (c == 0)       want = ex(16'h9000, 0, 1, 0, 16'd0, 16'h0);
         else if (c <= 12) want = ex((k % 2 == 0) ? 16'hAAAA : 16'hBBBB, 1, 1, 0, 16'(k), 16'((1 << k) - 1));
         else              want = ex(16'h9000, 0, 0, 1, 16'd6, 16'h003F);
         compared++;
         if (obs !== want) begin
            $display("FAIL loop cyc%0d: got %h want %h", c, obs, want);
            mismatched++;
         end
         if (c == 5) begin
            start = 1'b1; load_enable = 1'b1; load_address = 4'd1; load_data = 16'h1234;
         end
         if (c == 6) begin
            start = 1'b0; load_enable = 1'b0;
         end
         if (c == 10) loop_mode = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_midrun();
      logic [50:0] want;
      int k;
      for (int a = 0; a < 6; a++) load(4'(a), 16'((a + 1) * 16'h0101));
      load(4'd6, 16'hFFFF);
      cpu_output = 8'h01;
      do_start();
      for (int c = 0; c < 12; c++) begin
         k = (c - 1) / 2;
         want = (c == 0) ? ex(16'h9000, 0, 1, 0, 16'd0, 16'h0)
                         : ex(16'((k + 1) * 16'h0101), 1, 1, 0, 16'(k), 16'((1 << k) - 1));
         compared++;
         if (obs !== want) begin
            $display("FAIL run1 cyc%0d: got %h want %h", c, obs, want);
            mismatched++;
         end
         if (c < 11) step();
      end
      reset_in = 1'b1;
      step();
      reset_in = 1'b0;
      compared++;
      if (obs !== ex(16'h9000, 0, 0, 0, 16'h0, 16'h0)) begin
         $display("FAIL midrun_reset: got %h want %h", obs, ex(16'h9000, 0, 0, 0, 16'h0, 16'h0));
         mismatched++;
      end
      do_start();
      for (int c = 0; c < 15; c++) begin
         k = (c - 1) / 2;
         if (c == 0)       want = ex(16'h9000, 0, 1, 0, 16'd0, 16'h0);
         else if (c <= 12) want = ex(16'((k + 1) * 16'h0101), 1, 1, 0, 16'(k), 16'((1 << k) - 1));
         else              want = ex(16'h9000, 0, 0, 1, 16'd6, 16'h003F);
         compared++;
         if (obs !== want) begin
            $display("FAIL replay cyc%0d: got %h want %h", c, obs, want);
            mismatched++;
         end
         step();
      end
   endtask

   task automatic test_empty();
      logic [50:0] want;
      load(4'd0, 16'hFFFF);
      loop_mode = 1'b1;
      do_start();
      for (int c = 0; c < 4; c++) begin
         want = (c == 0) ? ex(16'h9000, 0, 1, 0, 16'd0, 16'h0) : ex(16'h9000, 0, 0, 1, 16'd0, 16'h0);
         compared++;
         if (obs !== want) begin
            $display("FAIL empty cyc%0d: got %h want %h", c, obs, want);
            mismatched++;
         end
         step();
      end
      loop_mode = 1'b0;
   endtask

   // Full memory with no halt word: last address acts as halt, looping first then stopping.
   task automatic test_implicit_halt();
      logic [50:0] want;
      int k;
      for (int a = 0; a < DEPTH; a++) load(4'(a), 16'(16'h0100 + a));
      cpu_output = 8'h00;
      loop_mode = 1'b1;
      do_start();
      for (int c = 0; c < 67; c++) begin
         k = (c - 1) / 2;
         if (c == 0)       want = ex(16'h9000, 0, 1, 0, 16'd0, 16'h0);
         else if (c <= 64) want = ex(16'(16'h0100 + (k % DEPTH)), 1, 1, 0, 16'(k), 16'h0);
         else              want = ex(16'h9000, 0, 0, 1, 16'd32, 16'h0);
         compared++;
         if (obs !== want) begin
            $display("FAIL imphalt cyc%0d: got %h want %h", c, obs, want);
            mismatched++;
         end
         if (c == 40) loop_mode = 1'b0;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_loop();
      test_reset_midrun();
      test_empty();
      test_implicit_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
